// File: rtl/seq_gen_fsm.sv
// Serial pattern generator: shifts PAT out MSB-first rep_num times with a
// programmable idle gap between repetitions, under a valid/ready handshake.
module seq_gen_fsm #(
    parameter int unsigned         PAT_W = 6,
    parameter logic [PAT_W-1:0]    PAT   = 6'b100110,
    parameter int unsigned         REP_W = 8,
    parameter int unsigned         GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] rep_num,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    input  logic             dout_rdy,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [REP_W-1:0]   rep_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_len_q;
    logic               dout_q;
    logic               dout_vld_q;
    logic               busy_q;
    logic               done_q;
    logic               xfer;

    assign xfer = dout_vld_q & dout_rdy;

    // Burst sequencer; every action in SHIFT is gated by a completed transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            gap_len_q  <= '0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (rep_num != '0) begin
                            state_q    <= SHIFT;
                            rep_q      <= rep_num;
                            gap_len_q  <= gap_len;
                            idx_q      <= IDX_W'(PAT_W - 1);
                            dout_q     <= PAT[PAT_W-1];
                            dout_vld_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        idx_q      <= '0;
                        rep_q      <= '0;
                        gap_q      <= '0;
                        dout_q     <= 1'b0;
                        dout_vld_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (xfer) begin
                        if (idx_q != '0) begin
                            idx_q  <= idx_q - IDX_W'(1);
                            dout_q <= PAT[idx_q - IDX_W'(1)];
                        end else if (rep_q > REP_W'(1)) begin
                            rep_q <= rep_q - REP_W'(1);
                            if (gap_len_q != '0) begin
                                state_q    <= GAP;
                                gap_q      <= gap_len_q;
                                dout_q     <= 1'b0;
                                dout_vld_q <= 1'b0;
                            end else begin
                                idx_q  <= IDX_W'(PAT_W - 1);
                                dout_q <= PAT[PAT_W-1];
                            end
                        end else begin
                            state_q    <= IDLE;
                            rep_q      <= '0;
                            dout_q     <= 1'b0;
                            dout_vld_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        idx_q      <= '0;
                        rep_q      <= '0;
                        gap_q      <= '0;
                        dout_q     <= 1'b0;
                        dout_vld_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (gap_q <= GAP_W'(1)) begin
                        state_q    <= SHIFT;
                        gap_q      <= '0;
                        idx_q      <= IDX_W'(PAT_W - 1);
                        dout_q     <= PAT[PAT_W-1];
                        dout_vld_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_gen_fsm.sv
// Bench for seq_gen_fsm: expected bits queued at start, popped on each transfer.
module tb_seq_gen_fsm;

    localparam logic [5:0] PATV = 6'b100110;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rep_num;
    logic [3:0] gap_len;
    logic       abort;
    logic       dout_rdy;
    logic       dout;
    logic       dout_vld;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    int last_xfer_cyc = -1;
    logic exp_q[$];

    seq_gen_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rep_num  (rep_num),
        .gap_len  (gap_len),
        .abort    (abort),
        .dout_rdy (dout_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every transfer must match the next queued pattern bit
    always @(negedge clk) begin
        if (!rst && dout_vld && dout_rdy) begin
            logic e;
            xfer_cnt++;
            last_xfer_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected cyc=%0d got dout=%0b, required no transfer", cyc, dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    failures++;
                    $display("FAIL sb_bit cyc=%0d got %0b required %0b", cyc, dout, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_burst(input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 5; i >= 0; i--)
                exp_q.push_back(PATV[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rep_num = '0; gap_len = '0; abort = 1'b0; dout_rdy = 1'b1;
        tick(); tick();
        checks++;
        if ({dout, dout_vld, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got %b required 0000", {dout, dout_vld, busy, done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rep_num = 8'd1; gap_len = 4'd0; dout_rdy = 1'b1; start = 1'b1;
        push_burst(1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (dout_vld !== (c >= 1 && c <= 6) || busy !== (c >= 1 && c <= 6) || done !== (c == 7)) begin
                failures++;
                $display("FAIL single_ctrl c=%0d got vld=%0b busy=%0b done=%0b", c, dout_vld, busy, done);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_remaining got %0d bits left required 0", exp_q.size());
        end
    endtask

    task automatic test_gap();
        logic ev;
        rep_num = 8'd3; gap_len = 4'd2; dout_rdy = 1'b1; start = 1'b1;
        push_burst(3);
        for (int c = 1; c <= 24; c++) begin
            tick();
            start = 1'b0;
            ev = (c >= 1 && c <= 6) || (c >= 9 && c <= 14) || (c >= 17 && c <= 22);
            checks++;
            if (dout_vld !== ev || busy !== (c <= 22) || done !== (c == 23)) begin
                failures++;
                $display("FAIL gap_ctrl c=%0d got vld=%0b busy=%0b done=%0b required vld=%0b busy=%0b done=%0b",
                         c, dout_vld, busy, done, ev, (c <= 22), (c == 23));
            end
            if (!ev) begin
                checks++;
                if (dout !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_dout c=%0d got %0b required 0", c, dout);
                end
            end
        end
    endtask

    task automatic test_stall();
        int x0;
        x0 = xfer_cnt;
        rep_num = 8'd2; gap_len = 4'd0; dout_rdy = 1'b1; start = 1'b1;
        push_burst(2);
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            dout_rdy = !(c == 3 || c == 4);
            if (c >= 3 && c <= 5) begin
                checks++;
                if (dout !== 1'b0 || dout_vld !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold c=%0d got dout=%0b vld=%0b required 0/1", c, dout, dout_vld);
                end
            end
            checks++;
            if (done !== (c == 15)) begin
                failures++;
                $display("FAIL stall_done c=%0d got %0b required %0b", c, done, (c == 15));
            end
            if (c == 1) x0 = x0 + 0;
        end
        dout_rdy = 1'b1;
        checks++;
        if (xfer_cnt - x0 != 12 || last_xfer_cyc != cyc - 16 + 14) begin
            failures++;
            $display("FAIL stall_count got %0d xfers last@%0d required 12 last@%0d",
                     xfer_cnt - x0, last_xfer_cyc, cyc - 16 + 14);
        end
    endtask

    task automatic test_zero_and_ignore();
        int x0;
        rep_num = 8'd0; gap_len = 4'd0; dout_rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || dout_vld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_rep got done=%0b vld=%0b busy=%0b required 1/0/0", done, dout_vld, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_rep_pulse got %0b required 0", done);
        end
        x0 = xfer_cnt;
        rep_num = 8'd2; start = 1'b1;
        push_burst(2);
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = (c == 3);
            rep_num = (c == 3) ? 8'd5 : 8'd2;
            checks++;
            if (done !== (c == 13)) begin
                failures++;
                $display("FAIL ignore_done c=%0d got %0b required %0b", c, done, (c == 13));
            end
        end
        start = 1'b0;
        checks++;
        if (xfer_cnt - x0 != 12) begin
            failures++;
            $display("FAIL ignore_count got %0d required 12", xfer_cnt - x0);
        end
    endtask

    task automatic test_abort();
        rep_num = 8'd2; gap_len = 4'd0; dout_rdy = 1'b1; start = 1'b1;
        push_burst(2);
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0;
            abort = (c == 4);
            if (c == 5) begin
                exp_q.delete();
                checks++;
                if (dout_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_idle got vld=%0b busy=%0b done=%0b required 0/0/0", dout_vld, busy, done);
                end
            end
            if (c == 6) begin
                rep_num = 8'd1; start = 1'b1;
                push_burst(1);
            end
            if (c == 7) begin
                checks++;
                if (dout_vld !== 1'b1 || dout !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_restart got vld=%0b dout=%0b required 1/1", dout_vld, dout);
                end
            end
            if (c >= 5) begin
                checks++;
                if (done !== (c == 13)) begin
                    failures++;
                    $display("FAIL abort_done c=%0d got %0b required %0b", c, done, (c == 13));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rep_num = 8'd2; gap_len = 4'd1; dout_rdy = 1'b1; start = 1'b1;
        push_burst(2);
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
            rst = (c == 3);
            if (c == 4) begin
                exp_q.delete();
                checks++;
                if ({dout, dout_vld, busy, done} !== 4'b0000) begin
                    failures++;
                    $display("FAIL rst_mid got %b required 0000", {dout, dout_vld, busy, done});
                end
            end
            if (c == 5) begin
                rep_num = 8'd1; start = 1'b1;
                push_burst(1);
            end
            if (c >= 6 && c <= 11) begin
                checks++;
                if (dout_vld !== 1'b1 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_burst c=%0d got vld=%0b busy=%0b required 1/1", c, dout_vld, busy);
                end
            end
            if (c >= 4) begin
                checks++;
                if (done !== (c == 12)) begin
                    failures++;
                    $display("FAIL rst_done c=%0d got %0b required %0b", c, done, (c == 12));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_remaining got %0d bits left required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_gap();
        tick();
        test_stall();
        tick();
        test_zero_and_ignore();
        tick();
        test_abort();
        tick();
        test_reset_mid();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen_fsm.md
Name: seq_gen_fsm

Overview:
Serial pattern generator, the transmit-side counterpart to the team's serial sequence checker. On a start pulse it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per accepted cycle, repeated rep_num times with a programmable zero-gap between repetitions. It drives checker test benches and the link bring-up stimulus path. It uses a valid/ready handshake so a downstream consumer can stall it.

Parameters:
PAT_W, 6, pattern length in bits (2..32)
PAT, 6'b100110, pattern value, transmitted MSB first
REP_W, 8, width of rep_num
GAP_W, 4, width of gap_len

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; accepted only when busy=0
rep_num  input  REP_W  repetitions to send; sampled when start is accepted
gap_len  input  GAP_W  idle cycles between repetitions; sampled when start is accepted
abort  input  1  synchronous cancel of the current burst
dout_rdy  input  1  consumer ready
dout  output  1  serial data bit
dout_vld  output  1  dout holds a valid pattern bit
busy  output  1  burst in progress
done  output  1  one-cycle pulse after the last bit of the last repetition transfers

Behaviour:
- All outputs are registered.
- Reset values: dout=0, dout_vld=0, busy=0, done=0, state IDLE, all counters 0. Reset mid-burst drops to IDLE with no done pulse.
- Transfer rule: a bit is transferred on an edge where dout_vld=1 and dout_rdy=1.
- Stall rule: while dout_vld=1 and dout_rdy=0, dout, dout_vld and all counters hold.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 with rep_num>=1: latch rep_num and gap_len; load bit index PAT_W-1 and rep counter = rep_num. Next cycle: SHIFT, busy=1, dout_vld=1, dout=PAT[PAT_W-1].
  - start=1 with rep_num=0: no bits are sent, state stays IDLE, done=1 next cycle.
- SHIFT, on each transfer:
  - Not the last bit: bit index decrements; dout becomes the next bit on the following cycle.
  - Last bit (index 0), rep counter >1, gap_len>0: go to GAP. dout_vld=0, dout=0; gap counter loaded with gap_len; rep counter decrements.
  - Last bit, rep counter >1, gap_len=0: stay in SHIFT with index reloaded to PAT_W-1, so repetitions run back-to-back with no bubble.
  - Last bit, rep counter =1: go to IDLE. busy=0, dout_vld=0, done=1 for exactly one cycle.
- GAP:
  - Lasts exactly gap_len cycles with dout_vld=0 and busy=1. dout_rdy is ignored.
  - Then returns to SHIFT with dout_vld=1 and dout=PAT[PAT_W-1].
- start while busy=1 is ignored; rep_num and gap_len changes during a burst have no effect.
- start is accepted in the same cycle done=1 (state is IDLE then).
- abort=1 in SHIFT or GAP: next cycle IDLE, dout_vld=0, busy=0, done=0. An in-flight bit whose transfer coincides with abort counts as transferred, but no done follows. abort in IDLE has no effect.
- abort and start in the same cycle while IDLE: start is accepted; abort is ignored.
- rst has priority over abort and start.
- Latency, with continuous ready: start at cycle 0 -> first bit at cycle 1. Last bit at cycle rep_num*PAT_W + (rep_num-1)*gap_len. done one cycle after that.
- Counter widths: bit index ceil(log2(PAT_W)), rep counter REP_W, gap counter GAP_W. No counter wraps; a maximum rep_num of 255 sends exactly 255 repetitions.

Test Plan:
- Defaults, rep_num=1, gap_len=0, dout_rdy=1, start at cycle 0 -> dout_vld=1 for cycles 1-6 with dout=1,0,0,1,1,0; done=1 at cycle 7 only; busy=1 for cycles 1-6.
- rep_num=3, gap_len=2 -> bits at cycles 1-6, 9-14, 17-22; dout_vld=0 at cycles 7-8 and 15-16; done at 23.
- rep_num=2, gap_len=0, dout_rdy low at cycles 3-4 -> dout=0 (pattern bit 3) held stable through cycles 3-5; 12 transfers total, last at cycle 14; done at cycle 15.
- rep_num=0 start -> no dout_vld, done at cycle 1. A start at cycle 3 during a 2-repetition burst -> ignored; exactly 12 bits are sent.
- abort at cycle 4 of a rep_num=2 burst -> dout_vld=0 and busy=0 from cycle 5, done never asserts. A new start at cycle 6 -> the pattern restarts from the MSB at cycle 7.
- rst asserted at cycle 3 mid-burst -> all outputs 0 at cycle 4. A start at cycle 5 after rst deasserts -> normal 6-bit burst from cycle 6.
